// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: RAW stall, redirect flush and external freeze.
// Tracks in-flight rd in EX/MEM/WB and counts stall/flush cycles.
module hazard_stall_ctrl #(
   parameter int WB_BYPASS = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk_HZD,
   input  logic             rst_n_HZD,
   input  logic             id_valid_HZD,
   input  logic [4:0]       id_rs1_HZD,
   input  logic             id_rs1_used_HZD,
   input  logic [4:0]       id_rs2_HZD,
   input  logic             id_rs2_used_HZD,
   input  logic [4:0]       id_rd_HZD,
   input  logic             id_regwrite_HZD,
   input  logic             ex_redirect_HZD,
   input  logic             stall_ext_HZD,
   output logic             en_PC_HZD,
   output logic             en_IFID_HZD,
   output logic             NOP_IFID_HZD,
   output logic             en_IDEX_HZD,
   output logic             NOP_IDEX_HZD,
   output logic             en_EXMEM_HZD,
   output logic             en_MEMWB_HZD,
   output logic             raw_hazard_HZD,
   output logic [CNT_W-1:0] stall_cnt_HZD,
   output logic [CNT_W-1:0] flush_cnt_HZD
);

   logic       ex_v, mem_v, wb_v;
   logic [4:0] ex_rd, mem_rd, wb_rd;
   logic       wb_chk;
   logic       rs1_hit, rs2_hit, raw;
   logic       sel_ext, sel_rdr, sel_raw, sel_norm;
   logic       ex_in_v;

   assign wb_chk = (WB_BYPASS == 0);

   // Compare ID sources against the checked scoreboard slots
   always_comb begin
      rs1_hit = id_rs1_used_HZD & (id_rs1_HZD != 5'd0) &
                ((ex_v & (ex_rd == id_rs1_HZD)) |
                 (mem_v & (mem_rd == id_rs1_HZD)) |
                 (wb_chk & wb_v & (wb_rd == id_rs1_HZD)));
      rs2_hit = id_rs2_used_HZD & (id_rs2_HZD != 5'd0) &
                ((ex_v & (ex_rd == id_rs2_HZD)) |
                 (mem_v & (mem_rd == id_rs2_HZD)) |
                 (wb_chk & wb_v & (wb_rd == id_rs2_HZD)));
      raw     = id_valid_HZD & (rs1_hit | rs2_hit);
   end

   // One-hot action select: freeze > flush > bubble > flow
   always_comb begin
      sel_ext  = stall_ext_HZD;
      sel_rdr  = ~stall_ext_HZD & ex_redirect_HZD;
      sel_raw  = ~stall_ext_HZD & ~ex_redirect_HZD & raw;
      sel_norm = ~stall_ext_HZD & ~ex_redirect_HZD & ~raw;
   end

   // Drive register enables and NOP inserts; all quiet in reset
   always_comb begin
      en_PC_HZD    = 1'b0;
      en_IFID_HZD  = 1'b0;
      NOP_IFID_HZD = 1'b0;
      en_IDEX_HZD  = 1'b0;
      NOP_IDEX_HZD = 1'b0;
      en_EXMEM_HZD = 1'b0;
      en_MEMWB_HZD = 1'b0;
      if (rst_n_HZD) begin
         unique case (1'b1)
            sel_ext: begin
            end
            sel_rdr: begin
               en_PC_HZD    = 1'b1;
               en_IFID_HZD  = 1'b1;
               NOP_IFID_HZD = 1'b1;
               en_IDEX_HZD  = 1'b1;
               NOP_IDEX_HZD = 1'b1;
               en_EXMEM_HZD = 1'b1;
               en_MEMWB_HZD = 1'b1;
            end
            sel_raw: begin
               en_IDEX_HZD  = 1'b1;
               NOP_IDEX_HZD = 1'b1;
               en_EXMEM_HZD = 1'b1;
               en_MEMWB_HZD = 1'b1;
            end
            sel_norm: begin
               en_PC_HZD    = 1'b1;
               en_IFID_HZD  = 1'b1;
               en_IDEX_HZD  = 1'b1;
               en_EXMEM_HZD = 1'b1;
               en_MEMWB_HZD = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign raw_hazard_HZD = rst_n_HZD & raw;

   // Bubbles, flushes and x0 writers enter EX as invalid
   assign ex_in_v = id_valid_HZD & id_regwrite_HZD &
                    (id_rd_HZD != 5'd0) & ~NOP_IDEX_HZD;

   // Shift the rd scoreboard unless the pipe is frozen
   always_ff @(posedge clk_HZD or negedge rst_n_HZD) begin
      if (!rst_n_HZD) begin
         ex_v   <= 1'b0;
         ex_rd  <= 5'd0;
         mem_v  <= 1'b0;
         mem_rd <= 5'd0;
         wb_v   <= 1'b0;
         wb_rd  <= 5'd0;
      end else if (!stall_ext_HZD) begin
         wb_v   <= mem_v;
         wb_rd  <= mem_rd;
         mem_v  <= ex_v;
         mem_rd <= ex_rd;
         ex_v   <= ex_in_v;
         ex_rd  <= id_rd_HZD;
      end
   end

   // Saturating bubble and flush counters
   always_ff @(posedge clk_HZD or negedge rst_n_HZD) begin
      if (!rst_n_HZD) begin
         stall_cnt_HZD <= '0;
         flush_cnt_HZD <= '0;
      end else begin
         if (sel_raw && (stall_cnt_HZD != {CNT_W{1'b1}}))
            stall_cnt_HZD <= stall_cnt_HZD + 1'b1;
         if (sel_rdr && (flush_cnt_HZD != {CNT_W{1'b1}}))
            flush_cnt_HZD <= flush_cnt_HZD + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three parameterisations share inputs;
// directed steps push expectations, a negedge monitor pops and checks.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1 = 5'd0;
   logic       id_rs1_used = 1'b0;
   logic [4:0] id_rs2 = 5'd0;
   logic       id_rs2_used = 1'b0;
   logic [4:0] id_rd = 5'd0;
   logic       id_regwrite = 1'b0;
   logic       ex_redirect = 1'b0;
   logic       stall_ext = 1'b0;

   always #5 clk = ~clk;

   // {en_PC,en_IFID,NOP_IFID,en_IDEX,NOP_IDEX,en_EXMEM,en_MEMWB,raw}
   localparam logic [7:0] CN = 8'b1101_0110;
   localparam logic [7:0] CR = 8'b0001_1111;
   localparam logic [7:0] Z  = 8'b0000_0000;

   logic [7:0]  a_ctl, b_ctl, c_ctl;
   logic [15:0] a_sc, a_fc, b_sc, b_fc;
   logic [3:0]  c_sc, c_fc;

   hazard_stall_ctrl #(.WB_BYPASS(1), .CNT_W(16)) dut_a (
      .clk_HZD(clk), .rst_n_HZD(rst_n), .id_valid_HZD(id_valid),
      .id_rs1_HZD(id_rs1), .id_rs1_used_HZD(id_rs1_used),
      .id_rs2_HZD(id_rs2), .id_rs2_used_HZD(id_rs2_used),
      .id_rd_HZD(id_rd), .id_regwrite_HZD(id_regwrite),
      .ex_redirect_HZD(ex_redirect), .stall_ext_HZD(stall_ext),
      .en_PC_HZD(a_ctl[7]), .en_IFID_HZD(a_ctl[6]),
      .NOP_IFID_HZD(a_ctl[5]), .en_IDEX_HZD(a_ctl[4]),
      .NOP_IDEX_HZD(a_ctl[3]), .en_EXMEM_HZD(a_ctl[2]),
      .en_MEMWB_HZD(a_ctl[1]), .raw_hazard_HZD(a_ctl[0]),
      .stall_cnt_HZD(a_sc), .flush_cnt_HZD(a_fc));

   hazard_stall_ctrl #(.WB_BYPASS(0), .CNT_W(16)) dut_b (
      .clk_HZD(clk), .rst_n_HZD(rst_n), .id_valid_HZD(id_valid),
      .id_rs1_HZD(id_rs1), .id_rs1_used_HZD(id_rs1_used),
      .id_rs2_HZD(id_rs2), .id_rs2_used_HZD(id_rs2_used),
      .id_rd_HZD(id_rd), .id_regwrite_HZD(id_regwrite),
      .ex_redirect_HZD(ex_redirect), .stall_ext_HZD(stall_ext),
      .en_PC_HZD(b_ctl[7]), .en_IFID_HZD(b_ctl[6]),
      .NOP_IFID_HZD(b_ctl[5]), .en_IDEX_HZD(b_ctl[4]),
      .NOP_IDEX_HZD(b_ctl[3]), .en_EXMEM_HZD(b_ctl[2]),
      .en_MEMWB_HZD(b_ctl[1]), .raw_hazard_HZD(b_ctl[0]),
      .stall_cnt_HZD(b_sc), .flush_cnt_HZD(b_fc));

   hazard_stall_ctrl #(.WB_BYPASS(1), .CNT_W(4)) dut_c (
      .clk_HZD(clk), .rst_n_HZD(rst_n), .id_valid_HZD(id_valid),
      .id_rs1_HZD(id_rs1), .id_rs1_used_HZD(id_rs1_used),
      .id_rs2_HZD(id_rs2), .id_rs2_used_HZD(id_rs2_used),
      .id_rd_HZD(id_rd), .id_regwrite_HZD(id_regwrite),
      .ex_redirect_HZD(ex_redirect), .stall_ext_HZD(stall_ext),
      .en_PC_HZD(c_ctl[7]), .en_IFID_HZD(c_ctl[6]),
      .NOP_IFID_HZD(c_ctl[5]), .en_IDEX_HZD(c_ctl[4]),
      .NOP_IDEX_HZD(c_ctl[3]), .en_EXMEM_HZD(c_ctl[2]),
      .en_MEMWB_HZD(c_ctl[1]), .raw_hazard_HZD(c_ctl[0]),
      .stall_cnt_HZD(c_sc), .flush_cnt_HZD(c_fc));

   typedef struct packed {
      logic [1:0]  sel;
      logic [7:0]  ctl;
      logic [15:0] sc;
      logic [15:0] fc;
      logic [15:0] id;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   nstep = 0;
   logic done = 1'b0;
   logic fin = 1'b0;

   // Monitor: one expectation per cycle, checked mid-cycle
   always @(negedge clk) begin
      exp_t e;
      logic [7:0]  gc;
      logic [15:0] gs, gf;
      if (q.size() > 0) begin
         e = q.pop_front();
         case (e.sel)
            2'd0:    begin gc = a_ctl; gs = a_sc; gf = a_fc; end
            2'd1:    begin gc = b_ctl; gs = b_sc; gf = b_fc; end
            default: begin
               gc = c_ctl;
               gs = {12'd0, c_sc};
               gf = {12'd0, c_fc};
            end
         endcase
         total++;
         if (gc !== e.ctl) begin
            bad++;
            $display("FAIL ctrl step=%0d dut=%0d got=%b want=%b",
                     e.id, e.sel, gc, e.ctl);
         end
         total++;
         if (gs !== e.sc) begin
            bad++;
            $display("FAIL stall_cnt step=%0d dut=%0d got=%0d want=%0d",
                     e.id, e.sel, gs, e.sc);
         end
         total++;
         if (gf !== e.fc) begin
            bad++;
            $display("FAIL flush_cnt step=%0d dut=%0d got=%0d want=%0d",
                     e.id, e.sel, gf, e.fc);
         end
      end else if (done && !fin) begin
         total++;
         fin = 1'b1;
      end
   end

   task automatic step(input int sel, input logic rst,
                       input logic v,
                       input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic rw,
                       input logic rdr, input logic ext,
                       input logic [7:0] ec, input int esc,
                       input int efc);
      exp_t e;
      rst_n       = rst;
      id_valid    = v;
      id_rs1      = r1;
      id_rs1_used = u1;
      id_rs2      = r2;
      id_rs2_used = u2;
      id_rd       = rd;
      id_regwrite = rw;
      ex_redirect = rdr;
      stall_ext   = ext;
      e.sel = 2'(sel);
      e.ctl = ec;
      e.sc  = 16'(esc);
      e.fc  = 16'(efc);
      e.id  = 16'(nstep);
      nstep++;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic rst_step(input int sel);
      step(sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, 0, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk);
      #1;
      // WB_BYPASS=1: independent stream, x0, 2-cycle RAW
      rst_step(0);
      step(0, 1, 1, 10, 1, 11, 1, 1, 1, 0, 0, CN, 0, 0);
      step(0, 1, 1, 12, 1, 13, 1, 2, 1, 0, 0, CN, 0, 0);
      step(0, 1, 1, 14, 1, 15, 1, 3, 1, 0, 0, CN, 0, 0);
      step(0, 1, 1, 16, 1, 17, 1, 4, 1, 0, 0, CN, 0, 0);
      step(0, 1, 1, 20, 1, 0, 0, 0, 1, 0, 0, CN, 0, 0);
      step(0, 1, 1, 0, 1, 0, 1, 7, 0, 0, 0, CN, 0, 0);
      step(0, 1, 1, 1, 1, 0, 0, 5, 1, 0, 0, CN, 0, 0);
      step(0, 1, 1, 5, 1, 1, 1, 6, 1, 0, 0, CR, 0, 0);
      step(0, 1, 1, 5, 1, 1, 1, 6, 1, 0, 0, CR, 1, 0);
      step(0, 1, 1, 5, 1, 1, 1, 6, 1, 0, 0, CN, 2, 0);
      step(0, 1, 1, 10, 1, 11, 1, 0, 0, 0, 0, CN, 2, 0);
      step(0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, CN, 2, 0);

      // WB_BYPASS=0: 3-cycle RAW, redirect beats raw
      rst_step(1);
      step(1, 1, 1, 1, 1, 0, 0, 5, 1, 0, 0, CN, 0, 0);
      step(1, 1, 1, 5, 1, 1, 1, 6, 1, 0, 0, CR, 0, 0);
      step(1, 1, 1, 5, 1, 1, 1, 6, 1, 0, 0, CR, 1, 0);
      step(1, 1, 1, 5, 1, 1, 1, 6, 1, 0, 0, CR, 2, 0);
      step(1, 1, 1, 5, 1, 1, 1, 6, 1, 0, 0, CN, 3, 0);
      step(1, 1, 1, 6, 1, 0, 0, 7, 1, 1, 0, 8'hFF, 3, 0);
      step(1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, CN, 3, 1);
      step(1, 1, 1, 10, 1, 0, 0, 8, 1, 1, 0, 8'hFE, 3, 1);
      step(1, 1, 1, 8, 1, 11, 1, 0, 0, 0, 0, CN, 3, 2);

      // External freeze in the middle of a RAW stall
      rst_step(0);
      step(0, 1, 1, 1, 1, 0, 0, 5, 1, 0, 0, CN, 0, 0);
      step(0, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, CR, 0, 0);
      for (int i = 0; i < 4; i++)
         step(0, 1, 1, 5, 1, 0, 0, 6, 1, 0, 1, 8'h01, 1, 0);
      step(0, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, CR, 1, 0);
      step(0, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, CN, 2, 0);

      // CNT_W=4 saturation, then async reset mid-stall
      rst_step(2);
      step(2, 1, 1, 1, 1, 0, 0, 5, 1, 0, 0, CN, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(2, 1, 1, 5, 1, 0, 0, 5, 1, 0, 0, CR,
              (2*i > 15) ? 15 : 2*i, 0);
         step(2, 1, 1, 5, 1, 0, 0, 5, 1, 0, 0, CR,
              (2*i+1 > 15) ? 15 : 2*i+1, 0);
         step(2, 1, 1, 5, 1, 0, 0, 5, 1, 0, 0, CN,
              (2*i+2 > 15) ? 15 : 2*i+2, 0);
      end
      step(2, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, CR, 15, 0);
      step(2, 0, 1, 5, 1, 0, 0, 6, 1, 0, 0, Z, 0, 0);
      step(2, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, CN, 0, 0);

      done = 1'b1;
      wait (fin);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
